// File: rtl/pl_muldiv.sv
// Iterative RV32M multiply/divide unit for the EXE stage.
// Shift-add multiply and restoring divide, one bit per cycle, with pipeline stall.
module pl_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            cancel,
    output logic            busy,
    output logic            ready,
    output logic            stall,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2*XLEN-1:0]   p_q, p_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_sgn, b_sgn, sa, sb, neg_in;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div0, ovf, special;
    logic [XLEN-1:0]     spec_res;

    logic [XLEN:0]       sum;
    logic [XLEN:0]       t;
    logic                ge;
    logic [XLEN-1:0]     rsub;
    logic [2*XLEN-1:0]   mul_nxt, div_nxt, step;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     mul_res, dval, div_res, final_res;

    // operand decode at issue time
    always_comb begin
        a_sgn  = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_sgn  = op[2] ? ~op[0] : ~op[1];
        sa     = a_sgn & a[XLEN-1];
        sb     = b_sgn & b[XLEN-1];
        mag_a  = sa ? -a : a;
        mag_b  = sb ? -b : b;
        neg_in = (op[2] & op[1]) ? sa : (sa ^ sb);
        div0   = op[2] & (b == '0);
        ovf    = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}})
                 & (b == '1);
        special = div0 | ovf;
        if (div0) begin
            spec_res = op[1] ? a : '1;
        end else begin
            spec_res = op[1] ? '0 : a;
        end
    end

    // one iteration: p holds {acc/remainder, multiplier/quotient}
    always_comb begin
        sum     = {1'b0, p_q[2*XLEN-1:XLEN]}
                  + (p_q[0] ? {1'b0, opb_q} : '0);
        mul_nxt = {sum, p_q[XLEN-1:1]};
        t       = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        ge      = t >= {1'b0, opb_q};
        rsub    = t[XLEN-1:0] - opb_q;
        div_nxt = ge ? {rsub, p_q[XLEN-2:0], 1'b1}
                     : {t[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
        step    = op_q[2] ? div_nxt : mul_nxt;
        prod_s  = neg_q ? -step : step;
        mul_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                       : prod_s[2*XLEN-1:XLEN];
        dval    = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        div_res = neg_q ? -dval : dval;
        final_res = op_q[2] ? div_res : mul_res;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opb_d    = opb_q;
        p_d      = p_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    op_d  = op;
                    neg_d = neg_in;
                    opb_d = mag_b;
                    p_d   = {{XLEN{1'b0}}, mag_a};
                    cnt_d = CW'(XLEN-1);
                    if (special) begin
                        result_d = spec_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    p_d = step;
                    if (cnt_q == '0) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            p_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opb_q    <= opb_d;
            p_q      <= p_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign ready  = (state_q == DONE);
    assign stall  = ((state_q == IDLE) & start & ~cancel) | busy;
    assign result = result_q;

endmodule

// File: tb/tb_pl_muldiv.sv
// Directed bench for pl_muldiv: latency, arithmetic, special cases,
// cancel, ignored starts, async reset and back-to-back issue.
module tb_pl_muldiv;
    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        ready;
    logic        stall;
    logic [31:0] result;

    int tests_run = 0;
    int tests_failed = 0;

    pl_muldiv #(.XLEN(32)) dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op),
        .a(a), .b(b), .cancel(cancel), .busy(busy),
        .ready(ready), .stall(stall), .result(result)
    );

    always #5 clk = ~clk;

    // Issues one op at a negedge and waits (bounded) for ready.
    // lat is the cycle offset of ready relative to the issue cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat,
                          output logic [31:0] res, output int ctl_err,
                          output logic rdy_after);
        lat = -1;
        res = 32'hDEAD_BEEF;
        ctl_err = 0;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        #1;
        if (stall !== 1'b1 || busy !== 1'b0) ctl_err++;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (ready === 1'b1) begin
                lat = n;
                res = result;
                if (stall !== 1'b0 || busy !== 1'b0) ctl_err++;
                break;
            end
            if (busy !== 1'b1 || stall !== 1'b1) ctl_err++;
            @(negedge clk);
        end
        @(negedge clk);
        rdy_after = ready;
    endtask

    task automatic test_reset();
        clrn = 1'b0; start = 1'b0; cancel = 1'b0;
        op = 3'd0; a = '0; b = '0;
        #3;
        tests_run++;
        if ({busy, ready, stall} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctl: got %b want 000", {busy, ready, stall});
        end
        tests_run++;
        if (result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_mul_latency();
        int lat; logic [31:0] res; int ce; logic ra;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, lat, res, ce, ra);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL mul_latency: got %0d want 33", lat);
        end
        tests_run++;
        if (res !== 32'hFFFF_FFEB) begin
            tests_failed++;
            $display("FAIL mul_result: got %h want ffffffeb", res);
        end
        tests_run++;
        if (ce !== 0) begin
            tests_failed++;
            $display("FAIL mul_stall_busy: %0d bad cycles want 0", ce);
        end
        tests_run++;
        if (ra !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_ready_pulse: got %b want 0", ra);
        end
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] xa  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] xb  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            int lat; logic [31:0] res; int ce; logic ra;
            run_op(ops[i], xa[i], xb[i], lat, res, ce, ra);
            tests_run++;
            if (lat !== 33 || res !== ex[i]) begin
                tests_failed++;
                $display("FAIL mulh_%0d: got %h lat %0d want %h lat 33",
                         i, res, lat, ex[i]);
            end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] xa  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'd100};
        logic [31:0] xb  [4] = '{32'd2, 32'd2, 32'd2, 32'd7};
        logic [31:0] ex  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'h7FFF_FFFC, 32'd2};
        for (int i = 0; i < 4; i++) begin
            int lat; logic [31:0] res; int ce; logic ra;
            run_op(ops[i], xa[i], xb[i], lat, res, ce, ra);
            tests_run++;
            if (lat !== 33 || res !== ex[i]) begin
                tests_failed++;
                $display("FAIL div_%0d: got %h lat %0d want %h lat 33",
                         i, res, lat, ex[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] xa  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] xb  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            int lat; logic [31:0] res; int ce; logic ra;
            run_op(ops[i], xa[i], xb[i], lat, res, ce, ra);
            tests_run++;
            if (lat !== 1 || res !== ex[i] || ra !== 1'b0) begin
                tests_failed++;
                $display("FAIL special_%0d: got %h lat %0d want %h lat 1",
                         i, res, lat, ex[i]);
            end
        end
    endtask

    task automatic test_cancel();
        int lat; logic [31:0] res; int ce; logic ra;
        logic seen;
        run_op(3'b111, 32'd100, 32'd7, lat, res, ce, ra);
        tests_run++;
        if (res !== 32'd2) begin
            tests_failed++;
            $display("FAIL cancel_prior: got %h want 2", res);
        end
        @(negedge clk);
        op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL cancel_busy_before: got %b want 1", busy);
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd2) begin
            tests_failed++;
            $display("FAIL cancel_after: busy %b ready %b result %h want 0 0 2",
                     busy, ready, result);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL cancel_no_ready: got %b want 0", seen);
        end
        start = 1'b1; cancel = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL cancel_idle_stall: got %b want 0", stall);
        end
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL cancel_idle_accept: busy %b ready %b want 0 0",
                     busy, ready);
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        @(negedge clk);
        op = 3'b000; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 3'b100; a = 32'd0; b = 32'd0;
        repeat (4) @(negedge clk);
        op = 3'b001; a = 32'd5; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 6;
        for (int n = 0; n < 40; n++) begin
            if (ready === 1'b1) break;
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc !== 33 || result !== 32'hFFFF_FFEB) begin
            tests_failed++;
            $display("FAIL ignore_start: got %h at %0d want ffffffeb at 33",
                     result, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; int ce; logic ra;
        @(negedge clk);
        op = 3'b000; a = 32'hFFFF; b = 32'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        tests_run++;
        if ({busy, ready, stall} !== 3'b000 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: ctl %b result %h want 000 0",
                     {busy, ready, stall}, result);
        end
        @(negedge clk);
        clrn = 1'b1;
        run_op(3'b000, 32'd3, 32'd4, lat, res, ce, ra);
        tests_run++;
        if (lat !== 33 || res !== 32'd12) begin
            tests_failed++;
            $display("FAIL reset_recover: got %h lat %0d want c lat 33",
                     res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        op = 3'b100; a = 32'd1000; b = 32'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        for (int n = 0; n < 40; n++) begin
            if (ready === 1'b1) break;
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc !== 33 || result !== 32'd100) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h at %0d want 64 at 33",
                     result, cyc);
        end
        op = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b0 || stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_pulse: ready %b stall %b want 0 1",
                     ready, stall);
        end
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (result !== 32'd100 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_hold: result %h busy %b want 64 1",
                     result, busy);
        end
        cyc = 2;
        for (int n = 0; n < 40; n++) begin
            if (ready === 1'b1) break;
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc !== 34 || result !== 32'd42) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h at %0d want 2a at 34",
                     result, cyc);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_mul_high();
        test_divide();
        test_special();
        test_cancel();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
